// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM user-port arbiter.
// Address layout on the controller port is {bank, row, col}.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      ACK  = 2'b10
   } arb_state_t;

   localparam int ARB_ADDR_WIDTH = 23;
   localparam int ARB_DATA_WIDTH = 32;

   localparam int COL_LSB  = 0;
   localparam int COL_W    = 9;
   localparam int ROW_LSB  = COL_LSB + COL_W;
   localparam int ROW_W    = 12;
   localparam int BANK_LSB = ROW_LSB + ROW_W;
   localparam int BANK_W   = 2;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [ARB_ADDR_WIDTH-1:0] make_addr(
      input logic [BANK_W-1:0] bank,
      input logic [ROW_W-1:0]  row,
      input logic [COL_W-1:0]  col
   );
      return {bank, row, col};
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Client-side and controller-side signal bundle of the arbiter.
// master = arbiter view, slave = clients plus controller view.
interface sdram_port_arbiter_if #(
   parameter int NUM_CLIENTS = 2,
   parameter int ADDR_WIDTH  = 23,
   parameter int DATA_WIDTH  = 32
);
   logic [NUM_CLIENTS-1:0]            c_req;
   logic [NUM_CLIENTS-1:0]            c_we;
   logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_addr;
   logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_wr_data;
   logic [NUM_CLIENTS-1:0]            c_ack;
   logic [NUM_CLIENTS-1:0]            c_err;
   logic [DATA_WIDTH-1:0]             c_rd_data;
   logic                              m_req;
   logic                              m_wr_en;
   logic                              m_rd_en;
   logic [ADDR_WIDTH-1:0]             m_addr;
   logic [DATA_WIDTH-1:0]             m_wr_data;
   logic                              m_ack;
   logic [DATA_WIDTH-1:0]             m_rd_data;

   modport master (
      input  c_req, c_we, c_addr, c_wr_data, m_ack, m_rd_data,
      output c_ack, c_err, c_rd_data, m_req, m_wr_en, m_rd_en, m_addr, m_wr_data
   );

   modport slave (
      output c_req, c_we, c_addr, c_wr_data, m_ack, m_rd_data,
      input  c_ack, c_err, c_rd_data, m_req, m_wr_en, m_rd_en, m_addr, m_wr_data
   );
endinterface

// File: rtl/sdram_arb_rr_pick.sv
// Combinational rotate-priority selector: first set req bit at or after rr_ptr.
module sdram_arb_rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int NUM_CLIENTS = 2,
   parameter int IW          = idx_width(NUM_CLIENTS)
)(
   input  logic [NUM_CLIENTS-1:0] req,
   input  logic [IW-1:0]          rr_ptr,
   output logic [IW-1:0]          grant,
   output logic                   any_req
);
   int idx;

   // Walk from the farthest offset down so the nearest requester wins last.
   always_comb begin
      grant   = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr) + i) % NUM_CLIENTS;
         if (req[idx]) begin
            grant   = IW'(idx);
            any_req = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin share of the sdram_controller user port; one transaction in flight, registered outputs.
// Grant to m_req 1 cycle, m_ack to c_ack 1 cycle; optional ack watchdog under ARB_TIMEOUT_EN.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_CLIENTS    = 2,
   parameter int ADDR_WIDTH     = ARB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = ARB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 1024
)(
   input  logic                  fpga_clk,
   input  logic                  fpga_reset,
   sdram_port_arbiter_if.master  bus
);
   localparam int IW = idx_width(NUM_CLIENTS);

   arb_state_t              state, state_nxt;
   logic [IW-1:0]           rr_ptr, rr_ptr_nxt, grant, grant_nxt, pick;
   logic                    any_req, timeout_hit;
   logic [NUM_CLIENTS-1:0]  grant_oh;
   logic                    m_req_q, m_req_nxt, m_wr_en_q, m_wr_en_nxt, m_rd_en_q, m_rd_en_nxt;
   logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_nxt;
   logic [DATA_WIDTH-1:0]   m_wr_data_q, m_wr_data_nxt, c_rd_data_q, c_rd_data_nxt;
   logic [NUM_CLIENTS-1:0]  c_ack_q, c_ack_nxt;

   sdram_arb_rr_pick #(.NUM_CLIENTS(NUM_CLIENTS), .IW(IW)) u_pick (
      .req     (bus.c_req),
      .rr_ptr  (rr_ptr),
      .grant   (pick),
      .any_req (any_req)
   );

   assign grant_oh = NUM_CLIENTS'(1) << grant;

   always_ff @(posedge fpga_clk or posedge fpga_reset) begin
      if (fpga_reset) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant       <= '0;
         m_req_q     <= 1'b0;
         m_wr_en_q   <= 1'b0;
         m_rd_en_q   <= 1'b0;
         m_addr_q    <= '0;
         m_wr_data_q <= '0;
         c_ack_q     <= '0;
         c_rd_data_q <= '0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_ptr_nxt;
         grant       <= grant_nxt;
         m_req_q     <= m_req_nxt;
         m_wr_en_q   <= m_wr_en_nxt;
         m_rd_en_q   <= m_rd_en_nxt;
         m_addr_q    <= m_addr_nxt;
         m_wr_data_q <= m_wr_data_nxt;
         c_ack_q     <= c_ack_nxt;
         c_rd_data_q <= c_rd_data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req) state_nxt = BUSY;
         BUSY:    if (bus.m_ack || timeout_hit) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant_nxt     = grant;
      rr_ptr_nxt    = rr_ptr;
      m_req_nxt     = m_req_q;
      m_wr_en_nxt   = m_wr_en_q;
      m_rd_en_nxt   = m_rd_en_q;
      m_addr_nxt    = m_addr_q;
      m_wr_data_nxt = m_wr_data_q;
      c_ack_nxt     = c_ack_q;
      c_rd_data_nxt = c_rd_data_q;
      unique case (state)
         IDLE: if (any_req) begin
            grant_nxt     = pick;
            m_req_nxt     = 1'b1;
            m_wr_en_nxt   = bus.c_we[pick];
            m_rd_en_nxt   = ~bus.c_we[pick];
            m_addr_nxt    = bus.c_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            m_wr_data_nxt = bus.c_wr_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
         end
         BUSY: if (bus.m_ack || timeout_hit) begin
            m_req_nxt   = 1'b0;
            m_wr_en_nxt = 1'b0;
            m_rd_en_nxt = 1'b0;
            c_ack_nxt   = grant_oh;
            rr_ptr_nxt  = (grant == IW'(NUM_CLIENTS - 1)) ? '0 : grant + IW'(1);
            if (timeout_hit)    c_rd_data_nxt = '0;
            else if (m_rd_en_q) c_rd_data_nxt = bus.m_rd_data;
         end
         ACK:     c_ack_nxt = '0;
         default: ;
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]            timer;
   logic [NUM_CLIENTS-1:0] c_err_q;

   // A real ack in the limit cycle takes precedence over the watchdog.
   assign timeout_hit = (state == BUSY) && !bus.m_ack && (timer == TIMER_LAST);

   always_ff @(posedge fpga_clk or posedge fpga_reset) begin
      if (fpga_reset) begin
         timer   <= '0;
         c_err_q <= '0;
      end else begin
         timer   <= (state == BUSY) ? timer + 16'd1 : '0;
         c_err_q <= timeout_hit ? grant_oh : '0;
      end
   end

   assign bus.c_err = c_err_q;
`else
   assign timeout_hit = 1'b0;
   assign bus.c_err   = '0;
`endif

   assign bus.m_req     = m_req_q;
   assign bus.m_wr_en   = m_wr_en_q;
   assign bus.m_rd_en   = m_rd_en_q;
   assign bus.m_addr    = m_addr_q;
   assign bus.m_wr_data = m_wr_data_q;
   assign bus.c_ack     = c_ack_q;
   assign bus.c_rd_data = c_rd_data_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: transaction table plus reset, stray-ack and watchdog sequences.
module tb_sdram_port_arbiter;
   import sdram_arb_pkg::*;

   logic fpga_clk;
   logic fpga_reset;
   int   total;
   int   bad;

   sdram_port_arbiter_if #(.NUM_CLIENTS(2), .ADDR_WIDTH(23), .DATA_WIDTH(32)) bus ();

   sdram_port_arbiter #(
      .NUM_CLIENTS(2), .ADDR_WIDTH(23), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
   ) dut (
      .fpga_clk   (fpga_clk),
      .fpga_reset (fpga_reset),
      .bus        (bus)
   );

   initial fpga_clk = 1'b0;
   always #3 fpga_clk = ~fpga_clk;

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  we;
      logic [22:0] a0;
      logic [22:0] a1;
      logic [31:0] d0;
      logic [31:0] d1;
      int          delay;
      logic [31:0] rdata;
      int          exp_client;
      int          exp_wait;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [9];

   localparam logic [22:0] ADDR_A = {2'b00, 12'hfff, 9'h001};
   localparam logic [22:0] ADDR_C = make_addr(2'd1, 12'h010, 9'h020);
   localparam logic [22:0] ADDR_D = make_addr(2'd2, 12'h3c3, 9'h1ff);
   localparam logic [22:0] ADDR_E = make_addr(2'd3, 12'h001, 9'h000);
   localparam logic [22:0] ADDR_F = make_addr(2'd0, 12'h800, 9'h100);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [22:0] a0,
                        input logic [22:0] a1, input logic [31:0] d0, input logic [31:0] d1);
      bus.c_req     = req;
      bus.c_we      = we;
      bus.c_addr    = {a1, a0};
      bus.c_wr_data = {d1, d0};
   endtask

   // Controller model: waits for m_req, holds it `delay` observed cycles, then acks once.
   task automatic serve(input int delay, input logic [31:0] rdata, input int exp_client,
                        input logic [22:0] exp_addr, input logic exp_we, input logic [31:0] exp_wdata,
                        input int exp_wait, input logic [31:0] exp_rd);
      int         waited;
      logic [1:0] oh;
      oh     = 2'b01 << exp_client;
      waited = 0;
      do begin
         @(negedge fpga_clk);
         waited++;
      end while (bus.m_req !== 1'b1 && waited < 20);
      check("req_latency", 64'(waited), 64'(exp_wait));
      for (int j = 0; j < delay; j++) begin
         check("busy_hold",
               64'({bus.m_req, bus.m_wr_en, bus.m_rd_en, bus.m_addr, bus.m_wr_data, bus.c_ack}),
               64'({1'b1, exp_we, ~exp_we, exp_addr, exp_wdata, 2'b00}));
         if (j == delay - 1) begin
            bus.m_ack     = 1'b1;
            bus.m_rd_data = rdata;
         end
         @(negedge fpga_clk);
      end
      check("ack_pulse",
            64'({bus.m_req, bus.m_wr_en, bus.m_rd_en, bus.c_ack, bus.c_err, bus.c_rd_data}),
            64'({3'b000, oh, 2'b00, exp_rd}));
      bus.m_ack     = 1'b0;
      bus.m_rd_data = 32'h5a5a_5a5a;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      total = 0;
      bad   = 0;
      //          req    we     a0      a1      d0            d1            dly rdata         cl wt exp_rd
      vecs[0] = '{2'b01, 2'b01, ADDR_A, ADDR_C, 32'h0000_ff01, 32'h0,       8, 32'h0,        0, 1, 32'h0};
      vecs[1] = '{2'b10, 2'b00, ADDR_A, ADDR_A, 32'h0000_ff01, 32'h0,       3, 32'h0000_ff01, 1, 2, 32'h0000_ff01};
      vecs[2] = '{2'b11, 2'b01, ADDR_C, ADDR_D, 32'h1234_5678, 32'h0,       2, 32'hdead_0000, 0, 2, 32'h0000_ff01};
      vecs[3] = '{2'b11, 2'b01, ADDR_C, ADDR_D, 32'h1234_5678, 32'h0,       4, 32'h0000_beef, 1, 2, 32'h0000_beef};
      vecs[4] = '{2'b11, 2'b00, ADDR_E, ADDR_D, 32'h0,         32'h0,       1, 32'hcafe_0001, 0, 2, 32'hcafe_0001};
      vecs[5] = '{2'b11, 2'b10, ADDR_E, ADDR_F, 32'h0,         32'h5555_aaaa, 2, 32'h1111_1111, 1, 2, 32'hcafe_0001};
      vecs[6] = '{2'b10, 2'b00, ADDR_E, ADDR_A, 32'h0,         32'h0,       1, 32'h0000_0007, 1, 2, 32'h0000_0007};
      vecs[7] = '{2'b01, 2'b01, ADDR_F, ADDR_A, 32'haaaa_5555, 32'h0,       2, 32'h2222_2222, 0, 2, 32'h0000_0007};
      vecs[8] = '{2'b01, 2'b00, ADDR_F, ADDR_A, 32'h0,         32'h0,       3, 32'haaaa_5555, 0, 2, 32'haaaa_5555};

      fpga_reset    = 1'b1;
      bus.m_ack     = 1'b0;
      bus.m_rd_data = 32'h5a5a_5a5a;
      drive(2'b00, 2'b00, '0, '0, '0, '0);
      #1;
      check("reset_state",
            64'({bus.m_req, bus.m_wr_en, bus.m_rd_en, bus.m_addr, bus.c_ack, bus.c_err}), 64'(0));
      check("reset_rd_data", 64'(bus.c_rd_data), 64'(0));
      repeat (2) @(negedge fpga_clk);
      fpga_reset = 1'b0;
      @(negedge fpga_clk);

      // Single write, read-back, contention rotation, pointer skip and wrap.
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
         serve(vecs[i].delay, vecs[i].rdata, vecs[i].exp_client,
               (vecs[i].exp_client == 1) ? vecs[i].a1 : vecs[i].a0,
               vecs[i].we[vecs[i].exp_client],
               (vecs[i].exp_client == 1) ? vecs[i].d1 : vecs[i].d0,
               vecs[i].exp_wait, vecs[i].exp_rd);
      end
      bus.c_req = 2'b00;

      // Stray m_ack while IDLE must be ignored.
      @(negedge fpga_clk);
      bus.m_ack     = 1'b1;
      bus.m_rd_data = 32'hffff_ffff;
      @(negedge fpga_clk);
      check("idle_stray_ack", 64'({bus.m_req, bus.c_ack, bus.c_rd_data}), 64'({3'b000, 32'haaaa_5555}));
      bus.m_ack = 1'b0;

      // Request raised in the ACK cycle, with a stray ack there too.
      drive(2'b01, 2'b01, ADDR_C, ADDR_D, 32'h0bad_f00d, 32'h0);
      serve(2, 32'h0, 0, ADDR_C, 1'b1, 32'h0bad_f00d, 1, 32'haaaa_5555);
      drive(2'b10, 2'b00, ADDR_C, ADDR_E, 32'h0, 32'h0);
      bus.m_ack = 1'b1;
      @(negedge fpga_clk);
      check("ack_cycle_no_grant", 64'({bus.m_req, bus.c_ack}), 64'(0));
      bus.m_ack = 1'b0;
      serve(2, 32'h1357_2468, 1, ADDR_E, 1'b0, 32'h0, 1, 32'h1357_2468);

      // Reset while BUSY: leave rr_ptr at 1 first so a reset pointer is observable.
      drive(2'b01, 2'b01, ADDR_D, ADDR_F, 32'h7777_0000, 32'h0);
      serve(1, 32'h0, 0, ADDR_D, 1'b1, 32'h7777_0000, 2, 32'h1357_2468);
      drive(2'b10, 2'b00, ADDR_D, ADDR_F, 32'h0, 32'h0);
      repeat (2) @(negedge fpga_clk);
      check("pre_reset_busy", 64'({bus.m_req, bus.m_rd_en, bus.m_addr}), 64'({2'b11, ADDR_F}));
      #1 fpga_reset = 1'b1;
      #1;
      check("async_reset_outs",
            64'({bus.m_req, bus.m_wr_en, bus.m_rd_en, bus.m_addr, bus.c_ack, bus.c_err}), 64'(0));
      check("async_reset_rd", 64'(bus.c_rd_data), 64'(0));
      drive(2'b11, 2'b11, ADDR_A, ADDR_C, 32'h0101_0101, 32'h0202_0202);
      repeat (2) begin
         @(negedge fpga_clk);
         check("reset_no_ack", 64'({bus.c_ack, bus.m_req}), 64'(0));
      end
      fpga_reset = 1'b0;
      serve(2, 32'h0, 0, ADDR_A, 1'b1, 32'h0101_0101, 1, 32'h0);

`ifdef ARB_TIMEOUT_EN
      // Watchdog: give c_rd_data a non-zero value, then never ack client 0.
      drive(2'b10, 2'b00, ADDR_A, ADDR_C, 32'h0, 32'h0);
      serve(2, 32'h2468_1357, 1, ADDR_C, 1'b0, 32'h0, 2, 32'h2468_1357);
      drive(2'b11, 2'b00, ADDR_E, ADDR_F, 32'h0, 32'h0);
      repeat (2) @(negedge fpga_clk);
      check("to_req_rise", 64'({bus.m_req, bus.m_addr}), 64'({1'b1, ADDR_E}));
      for (int k = 1; k < 16; k++) begin
         @(negedge fpga_clk);
         check("to_waiting", 64'({bus.m_req, bus.c_ack, bus.c_err}), 64'({1'b1, 4'b0000}));
      end
      @(negedge fpga_clk);
      check("to_fire", 64'({bus.m_req, bus.c_ack, bus.c_err, bus.c_rd_data}),
            64'({1'b0, 2'b01, 2'b01, 32'h0}));
      serve(2, 32'h0000_0001, 1, ADDR_F, 1'b0, 32'h0, 2, 32'h0000_0001);
`endif

      bus.c_req = 2'b00;
      @(negedge fpga_clk);
      check("final_ack_clear", 64'({bus.c_ack, bus.c_err, bus.m_req}), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Round-robin arbiter that shares the single user port of sdram_controller (fpga_req/fpga_ack handshake, {bank,row,col} address, 32-bit data) between NUM_CLIENTS requesters.
- Typical requesters: HDMI framebuffer reader, capture/pattern writer, memory self-test.
- Latches one client command, drives it to the controller until acknowledged, then returns ack and read data to that client.
- One transaction in flight at a time.

Parameters:
- NUM_CLIENTS, 2, number of requesters (2..4).
- ADDR_WIDTH, 23, controller address width ({bank 2, row 12, col 9}).
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 1024, ack watchdog limit (used only with ARB_TIMEOUT_EN).

Ports:
- fpga_clk  in  1  system clock, 166 MHz.
- fpga_reset  in  1  asynchronous, active-high reset.
- c_req  in  NUM_CLIENTS  per-client request, level.
- c_we  in  NUM_CLIENTS  per-client command: 1 = write, 0 = read.
- c_addr  in  NUM_CLIENTS*ADDR_WIDTH  packed addresses; client i at [i*AW +: AW].
- c_wr_data  in  NUM_CLIENTS*DATA_WIDTH  packed write data.
- c_ack  out  NUM_CLIENTS  one-cycle completion pulse to the granted client.
- c_err  out  NUM_CLIENTS  one-cycle timeout pulse, coincident with c_ack.
- c_rd_data  out  DATA_WIDTH  read data; valid in the c_ack cycle.
- m_req  out  1  to controller fpga_req.
- m_wr_en  out  1  to fpga_wr_en.
- m_rd_en  out  1  to fpga_rd_en.
- m_addr  out  ADDR_WIDTH  to fpga_addr.
- m_wr_data  out  DATA_WIDTH  to fpga_wr_data.
- m_ack  in  1  from fpga_ack; one-cycle completion.
- m_rd_data  in  DATA_WIDTH  from fpga_rd_data; valid when m_ack = 1.

Behaviour:
- Reset is fpga_reset, asynchronous, active-high. Clock is fpga_clk.
- Reset values: all outputs 0, state IDLE, rr_ptr 0, grant 0, timer 0. Reset mid-transaction aborts immediately with no ack to any client.
- State machine, all outputs registered:
  - IDLE: if any c_req bit is set, pick the first set bit searching rr_ptr, rr_ptr+1, … mod NUM_CLIENTS. Latch grant index, c_we, c_addr and c_wr_data of that client. Next cycle: m_req = 1, m_wr_en = we, m_rd_en = ~we, state BUSY. No request: stay in IDLE.
  - BUSY: m_* held stable. On m_ack = 1: m_req/m_wr_en/m_rd_en <= 0, c_ack[grant] <= 1, c_rd_data <= m_rd_data (reads) or unchanged (writes), rr_ptr <= (grant+1) mod NUM_CLIENTS, state ACK.
  - ACK: c_ack/c_err return to 0, state IDLE. Requests are not sampled in this cycle, so a client sees its ack before the arbiter samples again.
- Latency: c_req rise in IDLE at cycle T gives m_req = 1 at T+1. m_ack at cycle A gives c_ack = 1 at A+1. Minimum spacing between grants is 3 cycles plus controller latency.
- Clients hold c_req and command stable until c_ack. Back-to-back requests: keep c_req high with a new command from the cycle after c_ack.
- Client drops c_req after being latched: the transaction still completes and c_ack is still pulsed.
- m_ack in IDLE or ACK: ignored.
- Fairness: with all clients requesting continuously, grants rotate 0,1,…,N-1,0. No client waits more than N-1 transactions.
- c_rd_data is shared; only the client receiving c_ack may sample it.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit timer clears on entry to BUSY and counts each BUSY cycle.
  - At count TIMEOUT_CYCLES-1 without m_ack: drop m_req, pulse c_ack[grant] and c_err[grant] together, c_rd_data <= 0, advance rr_ptr, go to ACK.
  - If m_ack arrives in the same cycle as the limit, m_ack wins and c_err stays 0.
- Undefined: no timer; c_err tied to 0; BUSY waits indefinitely.

Decomposition:
- Shared package/include sdram_arb_pkg:
  - state encodings IDLE = 2'b00, BUSY = 2'b01, ACK = 2'b10;
  - default ADDR_WIDTH/DATA_WIDTH;
  - field offsets for {bank,row,col}.
- Sub-module sdram_arb_rr_pick: combinational rotate-priority selector.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index, any_req.
  - Reusable for a later multi-port write-buffer arbiter.

Test Plan:
- Single write: client 0 writes addr {0,12'hfff,9'h001}, data 32'hff01; controller model acks after 8 cycles. Required: m_req high for exactly the BUSY cycles, m_addr/m_wr_data stable, c_ack[0] a single pulse.
- Single read back: client 1 reads the same address; model returns 32'hff01. Required: c_rd_data = 32'hff01 in the c_ack[1] cycle, c_ack[0] stays 0.
- Contention: both clients request in the same cycle after reset. Required: grant order 0,1,0,1 over 4 transactions, each client acked twice.
- Simultaneous events: m_ack high in IDLE and a client request arriving in the ACK cycle. Required: stray ack ignored; the new request is granted only from IDLE, one cycle later.
- Reset mid-BUSY: assert fpga_reset with m_req high. Required: all outputs 0 asynchronously, no c_ack, rr_ptr = 0 afterwards.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, the model never acks. Required: c_ack and c_err pulse together 16 cycles after m_req rise, c_rd_data = 0. The next client is then granted.
